// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM encodings, requester IDs
// and the default memory depth.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  localparam int DEPTH_DEFAULT = 32;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational. When both ports request,
// the port that did not win last time is granted.
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_valid
);

  always_comb begin
    gnt = 2'b00;
    if (req_a && req_b) begin
      gnt = (last_grant == OWN_B) ? 2'b01 : 2'b10;
    end else if (req_a) begin
      gnt = 2'b01;
    end else if (req_b) begin
      gnt = 2'b10;
    end
  end

  assign gnt_valid = req_a | req_b;

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between port A (CPU) and port B (DMA),
// one access per three cycles, with registered read data and ack pulses.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_err,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_err,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_rdata
);

  // state     | meaning
  // ST_IDLE   | arbitrate; latch the winner's request
  // ST_ACCESS | drive memory from latched request; write strobe only here
  // ST_DONE   | owner's ack pulse is visible
  state_t        state_q, state_d;
  logic          owner_q, we_q, last_grant_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    gnt;
  logic          gnt_valid, take, gnt_owner, in_range;

  rr_arbiter2 u_rr (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid)
  );

  assign gnt_owner = gnt[1] ? OWN_B : OWN_A;
  // Only the range check is done here; the full address goes to memory.
  assign in_range  = (addr_q < AW'(DEPTH));
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mem_rw  = 1'b0;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          take    = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_rw  = we_q && in_range;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= OWN_A;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= OWN_B;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_err        <= 1'b0;
      b_err        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      if (take) begin
        owner_q      <= gnt_owner;
        we_q         <= (gnt_owner == OWN_B) ? b_we    : a_we;
        addr_q       <= (gnt_owner == OWN_B) ? b_addr  : a_addr;
        wdata_q      <= (gnt_owner == OWN_B) ? b_wdata : a_wdata;
        last_grant_q <= gnt_owner;
      end
      // Out-of-range clears rdata even for writes; in-range writes keep it.
      if (state_q == ST_ACCESS) begin
        if (owner_q == OWN_A) begin
          a_ack <= 1'b1;
          a_err <= !in_range;
          if (!in_range)  a_rdata <= '0;
          else if (!we_q) a_rdata <= mem_rdata;
        end else begin
          b_ack <= 1'b1;
          b_err <= !in_range;
          if (!in_range)  b_rdata <= '0;
          else if (!we_q) b_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised and directed bench for data_mem_arbiter against a completion-order
// memory model; the bench also provides the 32-word memory itself.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we  = '0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        a_ack, b_ack, a_err, b_err, mem_rw;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram [32];
  logic [31:0] ref_mem [32];
  logic [31:0] last_rd [2];
  int          n_chk = 0, n_bad = 0;
  int          wr_pulses = 0, exp_wr = 0;
  logic        prev_rw = 0, prev_a = 0, prev_b = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32) ? ram[mem_addr[4:0]] : 32'hBAD0_0000;
  always @(posedge clk) if (mem_rw) ram[mem_addr[4:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    return p != 0 ? b_ack : a_ack;
  endfunction
  function automatic logic err_of(input int p);
    return p != 0 ? b_err : a_err;
  endfunction
  function automatic logic [31:0] rd_of(input int p);
    return p != 0 ? b_rdata : a_rdata;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_rw = 0; prev_a = 0; prev_b = 0;
    end else begin
      if (mem_rw) wr_pulses++;
      chk("both_ack", a_ack & b_ack, 0);
      chk("rw_range", mem_rw && (mem_addr >= 32), 0);
      chk("rw_once", mem_rw & prev_rw, 0);
      chk("ack_pulse", (a_ack & prev_a) | (b_ack & prev_b), 0);
      prev_rw = mem_rw; prev_a = a_ack; prev_b = b_ack;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
  task automatic issue(input int p, input bit w, input logic [31:0] ad,
                       input logic [31:0] wd, input int hold, input int lat_exp);
    int lat = 0;
    bit done = 0;
    logic [31:0] exp_rd;
    req[p] = 1'b1; we[p] = w; addr[p] = ad; wdata[p] = wd;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (hold > 0 && lat == hold) begin
        req[p] = 1'b0; addr[p] = $urandom; wdata[p] = $urandom; we[p] = ~w;
      end
      if (ack_of(p)) done = 1;
    end
    req[p] = 1'b0;
    chk($sformatf("ack_seen p%0d", p), done, 1);
    if (!done) return;
    exp_rd = (ad >= 32) ? 32'h0 : (w ? last_rd[p] : ref_mem[ad[4:0]]);
    chk($sformatf("err p%0d a%0d", p, ad), err_of(p), ad >= 32);
    chk($sformatf("rdata p%0d a%0d", p, ad), rd_of(p), exp_rd);
    if (lat_exp > 0) chk($sformatf("lat p%0d", p), lat, lat_exp);
    else             chk($sformatf("lat_rng p%0d", p), (lat >= 2 && lat <= 5), 1);
    last_rd[p] = exp_rd;
    if (w && ad < 32) begin
      ref_mem[ad[4:0]] = wd;
      exp_wr++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    last_rd[0] = '0; last_rd[1] = '0;

    #3;
    chk("rst mem_rw", mem_rw, 0);
    chk("rst acks", {a_ack, b_ack}, 0);
    chk("rst errs", {a_err, b_err}, 0);
    chk("rst rdata", {a_rdata, b_rdata}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    do_reset();

    // reset during a write access
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5; wdata[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("mw rw_pre", mem_rw, 1);
    chk("mw addr_pre", mem_addr, 5);
    rst = 1'b1; #1;
    chk("mw rw_drop", mem_rw, 0);
    chk("mw addr_rst", mem_addr, 0);
    chk("mw wdata_rst", mem_wdata, 0);
    req[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("mw no_ack", {a_ack, a_err, a_rdata}, 0);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 1, 5, 32'hCAFE_0005, 0, 2);

    // single write then read
    issue(0, 1, 3, 32'h1234_5678, 0, 2);
    issue(0, 0, 3, 32'h0, 0, 2);
    chk("wr_rd a_rdata", a_rdata, 32'h1234_5678);

    // contention from reset: A favoured first, then alternation
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 3; addr[1] = 8;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("cont a_ack c%0d", k), a_ack, (k == 2 || k == 8));
      chk($sformatf("cont b_ack c%0d", k), b_ack, (k == 5 || k == 11));
      if (a_ack) chk("cont a_rdata", a_rdata, ref_mem[3]);
      if (b_ack) chk("cont b_rdata", b_rdata, ref_mem[8]);
    end
    req = 2'b00;
    last_rd[0] = ref_mem[3]; last_rd[1] = ref_mem[8];
    @(posedge clk); #1;

    // out of range
    issue(1, 0, 32, 32'h0, 0, 2);
    issue(1, 1, 40, 32'hFFFF_FFFF, 0, 2);
    issue(1, 0, 8, 32'h0, 0, 2);

    // A withdraws after grant and scrambles inputs; B served next
    fork
      issue(0, 1, 10, 32'h0000_0055, 1, 2);
      issue(1, 0, 10, 32'h0, 0, 5);
    join
    chk("wd b_rdata", b_rdata, 32'h0000_0055);

    // back-to-back B writes then reads
    for (int i = 0; i < 4; i++) issue(1, 1, i, 32'h10 + i, 0, 2);
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, i, 32'h0, 0, 2);
      chk($sformatf("b2b rd%0d", i), b_rdata, 32'h10 + i);
    end

    // randomised traffic from both ports
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        issue(0, $urandom_range(0, 1), $urandom_range(0, 39), $urandom, 0, 0);
      end
      for (int j = 0; j < 30; j++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        issue(1, $urandom_range(0, 1), $urandom_range(0, 39), $urandom, 0, 0);
      end
    join

    repeat (3) @(posedge clk);
    #1;
    chk("write pulses", wr_pulses, exp_wr);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port 32-word data memory between two requesters: port A (CPU load/store path) and port B (loader/debug DMA).
- Serialises accesses and drives the memory's address, write-data and read/write lines.
- Guarantees the level-sensitive write line is high only during a granted write cycle.
- Returns registered read data with a one-cycle ack pulse to the requester it served.

Parameters:
- DEPTH, 32, number of memory words; word addresses at or above DEPTH are out of range.
- AW, 32, address width on all ports.
- DW, 32, data width on all ports.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request; held high with a_we/a_addr/a_wdata stable until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  AW  port A word address.
- a_wdata  in  DW  port A write data.
- a_ack  out  1  port A one-cycle completion pulse.
- a_err  out  1  port A out-of-range flag; valid only with a_ack.
- a_rdata  out  DW  port A read data; valid with a_ack and held until the next port A ack.
- b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata: port B equivalents, identical widths and rules.
- mem_addr  out  AW  to memory DAddr.
- mem_wdata  out  DW  to memory DataIn.
- mem_rw  out  1  to memory DataMemRW; 1 = write.
- mem_rdata  in  DW  from memory DataOut.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, mem_rw=0 immediately (combinational from state), mem_addr=0, mem_wdata=0.
  - a_ack=b_ack=0, a_err=b_err=0, a_rdata=b_rdata=0.
  - Round-robin pointer favours A (last_grant=B).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port not granted last (round robin).
  - On grant: latch owner, we, addr and wdata into internal registers; update last_grant; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - mem_rw = latched_we AND in_range, where in_range = (latched_addr < DEPTH).
  - At the clock edge ending ACCESS:
    - If read and in range: capture mem_rdata into the owner's rdata register.
    - If out of range: owner's rdata = 0 and err = 1.
    - Otherwise err = 0.
    - A write leaves the owner's rdata unchanged.
  - Go to DONE.
- DONE (one cycle):
  - Owner's ack = 1 (registered output); the other port's ack stays 0.
  - mem_rw = 0.
  - Next state is IDLE.
- Latency: req sampled in cycle 0 (IDLE) → ACCESS in cycle 1 → ack visible in cycle 2.
  - Peak throughput is one access per 3 cycles.
  - The losing requester waits at most one extra transaction.
- mem_addr and mem_wdata hold their last latched values in IDLE/DONE. No spurious write occurs because mem_rw=0 outside ACCESS.
- If req drops after the grant, the transaction still completes and acks. Input changes after the grant are ignored.
- Requester may re-assert req in the cycle after its ack. The request is arbitrated afresh in IDLE.
- If Reset asserts mid-ACCESS, mem_rw drops at once and no ack is issued. An in-flight write may or may not have landed; the requester must retry.
- Address truncation: only the comparison against DEPTH is performed here; mem_addr passes the full AW bits.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2;
  - port IDs OWN_A=1'b0, OWN_B=1'b1;
  - default DEPTH.
- One natural sub-module: rr_arbiter2 (inputs: two reqs, last_grant; outputs: one-hot grant plus grant-valid), purely combinational.
- FSM, latches and response registers stay in the top.

Test Plan:
- Reset mid-write: A write addr 5 = 0xDEAD_BEEF, Reset asserted during ACCESS → mem_rw falls in the same cycle; no a_ack; all outputs return to reset values.
- Single write/read: A write addr 3 = 0x1234_5678, then A read addr 3 → a_ack 2 cycles after each req, a_err=0, a_rdata=0x1234_5678; mem_rw high only in the write's ACCESS cycle.
- Contention: A and B both request every cycle from reset → grants alternate A,B,A,B; acks at cycles 2,5,8,11; no cycle has both acks high.
- Out of range: B read addr 32 → b_ack with b_err=1, b_rdata=0. B write addr 40 = 0xFFFF_FFFF → b_err=1, mem_rw never asserted, memory word 8 unchanged (verify by reading addr 8).
- Request withdrawal: A req high for the IDLE cycle only, then low → transaction completes with a_ack in cycle 2; B's pending request is served next.
- Back-to-back: B issues 4 sequential writes to addr 0..3 (values 0x10..0x13), re-requesting right after each ack, then reads all 4 back → read values match, and no mem_rw pulse appears outside ACCESS.
